// File: rtl/r32_bus_arbiter.sv
// Two-port round-robin arbiter for the R32 memory channel with a registered
// request stage and an in-order tag FIFO that steers responses back to their issuer.
module r32_bus_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] r0_address,
    input  logic [DW-1:0] r0_data,
    input  logic          r0_write,
    input  logic          r0_valid,
    output logic          r0_ready,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rvalid,
    input  logic          r0_rready,
    input  logic [AW-1:0] r1_address,
    input  logic [DW-1:0] r1_data,
    input  logic          r1_write,
    input  logic          r1_valid,
    output logic          r1_ready,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rvalid,
    input  logic          r1_rready,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_data,
    output logic          m_write,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          err_unexpected
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]    count;
    logic [PW-1:0]    head, tail;
    logic [DEPTH-1:0] tags;
    logic             last_grant;
    logic             winner, free, can_issue, accept, tag, nonempty, pop;

    assign free      = !m_valid || m_ready;
    // A same-cycle pop deliberately does not open a slot for a new request.
    assign can_issue = free && (count < CW'(DEPTH));

    always_comb begin
        winner = 1'b0;
        if (r0_valid && r1_valid) winner = !last_grant;
        else if (r1_valid)        winner = 1'b1;
    end

    assign r0_ready = can_issue && r0_valid && !winner;
    assign r1_ready = can_issue && r1_valid && winner;
    assign accept   = r0_ready || r1_ready;

    assign tag       = tags[head];
    assign nonempty  = (count != '0);
    assign r0_rdata  = s_data;
    assign r1_rdata  = s_data;
    assign r0_rvalid = s_valid && nonempty && !tag;
    assign r1_rvalid = s_valid && nonempty && tag;
    assign s_ready   = nonempty && (tag ? r1_rready : r0_rready);
    assign pop       = s_valid && s_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid    <= 1'b0;
            m_address  <= '0;
            m_data     <= '0;
            m_write    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            m_valid    <= 1'b1;
            m_address  <= winner ? r1_address : r0_address;
            m_data     <= winner ? r1_data    : r0_data;
            m_write    <= winner ? r1_write   : r0_write;
            last_grant <= winner;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tags  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tags[tail] <= winner;
                tail       <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   err_unexpected <= 1'b0;
        else if (s_valid && !nonempty) err_unexpected <= 1'b1;
    end
endmodule

// File: tb/tb_r32_bus_arbiter.sv
// Directed bench for r32_bus_arbiter: inputs change on the falling edge, combinational
// outputs are checked 1ns later, registered outputs at the following falling edge.
module tb_r32_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] r0_address, r0_data, r0_rdata, r1_address, r1_data, r1_rdata;
    logic        r0_write, r0_valid, r0_ready, r0_rvalid, r0_rready;
    logic        r1_write, r1_valid, r1_ready, r1_rvalid, r1_rready;
    logic [31:0] m_address, m_data, s_data;
    logic        m_write, m_valid, m_ready, s_valid, s_ready, err_unexpected;

    int n_chk  = 0;
    int n_fail = 0;

    r32_bus_arbiter #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .r0_address(r0_address), .r0_data(r0_data), .r0_write(r0_write), .r0_valid(r0_valid),
        .r0_ready(r0_ready), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
        .r1_address(r1_address), .r1_data(r1_data), .r1_write(r1_write), .r1_valid(r1_valid),
        .r1_ready(r1_ready), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
        .m_address(m_address), .m_data(m_data), .m_write(m_write), .m_valid(m_valid),
        .m_ready(m_ready), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .err_unexpected(err_unexpected)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        r0_address = '0; r0_data = '0; r0_write = 0; r0_valid = 0; r0_rready = 0;
        r1_address = '0; r1_data = '0; r1_write = 0; r1_valid = 0; r1_rready = 0;
        m_ready = 0; s_data = '0; s_valid = 0;
        nxt(); nxt();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_err", err_unexpected, 0);
        reset = 1'b1;

        // contention: grants alternate 0,1,0,1 starting with port 0
        r0_valid = 1; r1_valid = 1; m_ready = 1;
        r0_address = 32'h10; r1_address = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_r0_ready_%0d", i), r0_ready, (i % 2 == 0));
            chk($sformatf("cont_r1_ready_%0d", i), r1_ready, (i % 2 == 1));
            nxt();
            chk($sformatf("cont_m_addr_%0d", i), m_address, (i % 2 == 0) ? 32'h10 : 32'h20);
        end

        // outstanding limit: FIFO full, fifth request stalls
        r1_valid = 0; r0_address = 32'h30;
        #1;
        chk("full_r0_ready", r0_ready, 0);
        s_valid = 1; s_data = 32'h1111_0000; r0_rready = 1; r1_rready = 1;
        #1;
        chk("pop0_r0_rvalid", r0_rvalid, 1);
        chk("pop0_r1_rvalid", r1_rvalid, 0);
        chk("pop0_s_ready", s_ready, 1);
        chk("pop_no_bypass", r0_ready, 0);
        nxt();
        s_valid = 0;
        #1;
        chk("fifth_r0_ready", r0_ready, 1);
        nxt();
        r0_valid = 0;
        chk("fifth_m_addr", m_address, 32'h30);
        chk("fifth_m_valid", m_valid, 1);

        // response stall: head tag is 1 with r1_rready low
        s_valid = 1; s_data = 32'h2222_0001; r1_rready = 0;
        #1;
        chk("stall_s_ready", s_ready, 0);
        chk("stall_r1_rvalid", r1_rvalid, 1);
        chk("stall_r0_rvalid", r0_rvalid, 0);
        nxt();
        chk("stall_s_ready_hold", s_ready, 0);
        r1_rready = 1;
        #1;
        chk("stall_release", s_ready, 1);
        chk("stall_rdata", r1_rdata, 32'h2222_0001);
        nxt();
        // remaining tags: 0,1,0
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drain_r0_rvalid_%0d", i), r0_rvalid, (i != 1));
            chk($sformatf("drain_r1_rvalid_%0d", i), r1_rvalid, (i == 1));
            nxt();
        end
        s_valid = 0;
        #1;
        chk("drained_s_ready", s_ready, 0);

        // single read on port 0
        r0_address = 32'h100; r0_write = 0; r0_valid = 1;
        #1;
        chk("rd_r0_ready", r0_ready, 1);
        nxt();
        r0_valid = 0;
        chk("rd_m_addr", m_address, 32'h100);
        chk("rd_m_write", m_write, 0);
        s_data = 32'hDEADBEEF; s_valid = 1;
        #1;
        chk("rd_r0_rvalid", r0_rvalid, 1);
        chk("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
        chk("rd_r1_rvalid", r1_rvalid, 0);
        chk("rd_s_ready", s_ready, 1);
        nxt();
        s_valid = 0;
        chk("rd_m_valid_clear", m_valid, 0);

        // backpressure with a pending port 1 request
        r0_address = 32'h200; r0_data = 32'hA5A5A5A5; r0_write = 1; r0_valid = 1;
        nxt();
        r0_valid = 0; r0_write = 0; m_ready = 0;
        r1_address = 32'h300; r1_write = 0; r1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_r0_ready_%0d", i), r0_ready, 0);
            chk($sformatf("bp_r1_ready_%0d", i), r1_ready, 0);
            nxt();
            chk($sformatf("bp_m_addr_%0d", i), m_address, 32'h200);
            chk($sformatf("bp_m_data_%0d", i), m_data, 32'hA5A5A5A5);
            chk($sformatf("bp_m_write_%0d", i), m_write, 1);
        end
        m_ready = 1;
        #1;
        chk("bp_release_r1_ready", r1_ready, 1);
        nxt();
        r1_valid = 0; m_ready = 0;
        chk("bp_next_addr", m_address, 32'h300);
        chk("bp_next_write", m_write, 0);

        // asynchronous reset with m_valid=1 and two tags outstanding
        #2 reset = 1'b0;
        #1;
        chk("async_rst_m_valid", m_valid, 0);
        nxt();
        reset = 1'b1;
        r0_rready = 1; r1_rready = 1; s_valid = 0;
        #1;
        chk("post_rst_s_ready", s_ready, 0);
        chk("post_rst_err", err_unexpected, 0);
        r0_valid = 1; r1_valid = 1; m_ready = 1;
        #1;
        chk("post_rst_r0_grant", r0_ready, 1);
        chk("post_rst_r1_grant", r1_ready, 0);
        nxt();
        r0_valid = 0; r1_valid = 0;
        s_valid = 1;
        nxt();
        // FIFO now empty: an extra response is unexpected
        #1;
        chk("unexp_s_ready", s_ready, 0);
        chk("unexp_r0_rvalid", r0_rvalid, 0);
        chk("unexp_r1_rvalid", r1_rvalid, 0);
        nxt();
        s_valid = 0;
        chk("err_set", err_unexpected, 1);
        nxt(); nxt();
        chk("err_sticky", err_unexpected, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/r32_bus_arbiter.md
Name: r32_bus_arbiter

Overview:
- Shares the R32 memory request channel (m_*) and response channel (s_*) between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Round-robin arbitration drives a registered request stage.
- An in-order tag FIFO routes each response beat back to the requester that issued it.
- Sits between the core's fetch/LSU and the external memory interface.

Parameters:
- DEPTH, 4: maximum outstanding requests (tag FIFO depth); power of 2, at least 2.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clock  in  1  single clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- r0_address  in  AW  port 0 request address.
- r0_data  in  DW  port 0 write data.
- r0_write  in  1  port 0 write (1) or read (0).
- r0_valid  in  1  port 0 request valid.
- r0_ready  out  1  port 0 request accepted this cycle.
- r0_rdata  out  DW  port 0 response data.
- r0_rvalid  out  1  port 0 response valid.
- r0_rready  in  1  port 0 can take response.
- r1_address, r1_data, r1_write, r1_valid, r1_ready, r1_rdata, r1_rvalid, r1_rready: same as port 0, for port 1.
- m_address  out  AW  downstream request address.
- m_data  out  DW  downstream write data.
- m_write  out  1  downstream write flag.
- m_valid  out  1  downstream request valid.
- m_ready  in  1  downstream accepts request.
- s_data  in  DW  downstream response data.
- s_valid  in  1  downstream response valid.
- s_ready  out  1  arbiter accepts response.
- err_unexpected  out  1  sticky: response arrived with no outstanding request.

Behaviour:
- Handshake rule, all channels: a transfer occurs on a rising edge where valid and ready are both 1. Payload must stay stable while valid=1 and ready=0.
- Every request, read or write, yields exactly one response beat. Write responses carry don't-care data.
- Reset (reset=0, asynchronous) sets:
  - m_valid=0, m_address=0, m_data=0, m_write=0.
  - Tag FIFO empty (count=0).
  - last_grant=1, so port 0 wins first.
  - err_unexpected=0.
- Request stage:
  - free = !m_valid || m_ready.
  - can_issue = free && (count < DEPTH). No bypass: a pop in the same cycle does not free a slot early.
- Arbitration (combinational), when can_issue:
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - rX_ready=1 only for the winner. The loser's ready stays 0.
- On an accepted request (winner's valid && ready):
  - m_* load the winner's payload and m_valid=1.
  - The winner index is pushed into the tag FIFO.
  - last_grant=winner.
  - Request-to-m_valid latency is 1 cycle.
- If m_ready=1 and there is no accept, m_valid clears next cycle.
- Back-to-back: a new request can load in the same cycle the previous one drains, giving one request per cycle sustained.
- Response routing (combinational pass-through, zero latency):
  - tag = FIFO head.
  - rX_rdata = s_data for both ports.
  - r[tag]_rvalid = s_valid && count>0; the other port's rvalid=0.
  - s_ready = count>0 && r[tag]_rready.
  - Pop the head on s_valid && s_ready.
- Simultaneous push and pop: count unchanged, head advances, tail advances.
- Pointers wrap modulo DEPTH.
- s_valid=1 with count=0:
  - s_ready=0 and both rvalid=0.
  - err_unexpected sets on that clock and holds until reset.
- Reset mid-transaction: all in-flight requests and tags are discarded. The surrounding system must also reset memory.

Test Plan:
- Reset: assert reset=0 mid-run with m_valid=1 and count=2 -> m_valid=0 immediately (asynchronously); after release s_ready=0, err_unexpected=0, and the first contended grant goes to port 0.
- Single read: r0 addr 0x0000_0100 read, m_ready=1 -> next cycle m_address=0x100, m_write=0; s_data=0xDEADBEEF with s_valid=1 -> r0_rvalid=1, r0_rdata=0xDEADBEEF, r1_rvalid=0, s_ready=1.
- Contention: r0_valid=r1_valid=1 held for 4 cycles, m_ready=1 -> grants 0,1,0,1, one per cycle; the tag FIFO holds 0,1,0,1.
- Backpressure: m_ready=0 for 3 cycles with m_valid=1 (addr 0x200, data 0xA5A5A5A5, write) -> m_* unchanged, r0_ready=r1_ready=0; m_ready=1 -> the next pending request loads the following cycle.
- Outstanding limit (DEPTH=4): 4 accepted requests, no responses -> 5th request sees ready=0; one response popped -> 5th accepted on the next cycle.
- Response stall and error: head tag=1 with r1_rready=0 -> s_ready=0 until r1_rready=1. With count=0, s_valid=1 -> err_unexpected=1 and it stays 1.
